// File: rtl/pedestrian_request_unit.sv
// Pedestrian request unit: synchronizes and debounces the crossing push-button,
// requests a crossing from the traffic controller, drives WALK / DON'T WALK
// during the controller's all-lamps-off phase, then holds off new requests
// for a cooldown period.
module pedestrian_request_unit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WALK_CYCLES     = 10,
  parameter int FLASH_CYCLES    = 5,
  parameter int COOLDOWN_CYCLES = 20,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ped_raw,
  input  logic A1,
  input  logic A2,
  input  logic B,
  input  logic C,
  output logic button,
  output logic walk,
  output logic dont_walk,
  output logic req_lamp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_WALK,
    S_FLASH,
    S_COOLDOWN
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(COOLDOWN_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             db_level;
  logic             db_level_p1;
  logic [CNT_W-1:0] db_cnt;
  logic             press;
  logic             all_red;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             pending;
  logic             pending_nx;
  logic             button_nx;
  logic             walk_nx;
  logic             dont_walk_nx;
  logic             req_lamp_nx;

  // Two-flop synchronizer for the asynchronous push-button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= ped_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_level    <= 1'b0;
      db_level_p1 <= 1'b0;
      db_cnt      <= '0;
    end else begin
      db_level_p1 <= db_level;
      if (sync_p1 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync_p1;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press   = db_level & ~db_level_p1;
  assign all_red = ~A1 & ~A2 & ~B & ~C;

  // State, phase counter, pending flag and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pending   <= 1'b0;
      button    <= 1'b0;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      req_lamp  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pending   <= pending_nx;
      button    <= button_nx;
      walk      <= walk_nx;
      dont_walk <= dont_walk_nx;
      req_lamp  <= req_lamp_nx;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they move with it.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pending_nx = pending;
    unique case (state)
      S_IDLE: begin
        if (press) state_nx = S_REQUEST;
      end
      S_REQUEST: begin
        if (all_red) begin
          state_nx = S_WALK;
          cnt_nx   = WALK_LOAD;
        end
      end
      S_WALK: begin
        // Lamps leaving all-off is a safety abort and wins over expiry.
        if (!all_red) begin
          state_nx = S_COOLDOWN;
          cnt_nx   = COOL_LOAD;
        end else if (cnt == '0) begin
          state_nx = S_FLASH;
          cnt_nx   = FLASH_LOAD;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_FLASH: begin
        if (!all_red || cnt == '0) begin
          state_nx = S_COOLDOWN;
          cnt_nx   = COOL_LOAD;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_COOLDOWN: begin
        if (press) pending_nx = 1'b1;
        if (cnt == '0) begin
          // A press on the exit edge itself still counts as a queued request.
          state_nx   = (pending || press) ? S_REQUEST : S_IDLE;
          pending_nx = 1'b0;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: begin
        state_nx   = S_IDLE;
        cnt_nx     = '0;
        pending_nx = 1'b0;
      end
    endcase

    button_nx    = (state_nx == S_REQUEST);
    walk_nx      = (state_nx == S_WALK);
    req_lamp_nx  = (state_nx == S_REQUEST) || ((state_nx == S_COOLDOWN) && pending_nx);
    dont_walk_nx = 1'b1;
    if (state_nx == S_WALK) begin
      dont_walk_nx = 1'b0;
    end else if (state_nx == S_FLASH) begin
      // First FLASH cycle shows DON'T WALK, then it alternates.
      dont_walk_nx = (state == S_FLASH) ? ~dont_walk : 1'b1;
    end
  end

endmodule

// File: tb/tb_pedestrian_request_unit.sv
// Self-checking bench for pedestrian_request_unit: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_pedestrian_request_unit;

  localparam int DB   = 4;
  localparam int WC   = 10;
  localparam int FC   = 5;
  localparam int CC   = 20;

  logic clk = 1'b0;
  logic reset_n;
  logic ped_raw;
  logic A1, A2, B, C;
  logic button, walk, dont_walk, req_lamp;

  int errors = 0;
  int checks = 0;

  pedestrian_request_unit #(
    .DEBOUNCE_CYCLES(DB),
    .WALK_CYCLES(WC),
    .FLASH_CYCLES(FC),
    .COOLDOWN_CYCLES(CC),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ped_raw(ped_raw),
    .A1(A1),
    .A2(A2),
    .B(B),
    .C(C),
    .button(button),
    .walk(walk),
    .dont_walk(dont_walk),
    .req_lamp(req_lamp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_REQ, M_WALK, M_FLASH, M_COOL} mphase_t;
  mphase_t ph = M_IDLE;
  int      left = 0;
  bit      pend = 0;
  bit      lvl = 0;
  bit      rose = 0;
  bit      rawq[$];
  bit      hist[$];
  bit      s, ar, prs, all_diff;

  // Model advances once per rising edge; history queues stand in for the synchronizer and debounce.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rawq.delete();
      rawq.push_back(1'b0);
      rawq.push_back(1'b0);
      hist.delete();
      lvl  = 0;
      rose = 0;
      ph   = M_IDLE;
      left = 0;
      pend = 0;
    end else begin
      ar  = !(A1 || A2 || B || C);
      prs = rose;
      s   = rawq.pop_front();
      rawq.push_back(ped_raw);
      rose = 0;
      hist.push_back(s);
      if (hist.size() > DB) void'(hist.pop_front());
      if (hist.size() == DB) begin
        all_diff = 1;
        foreach (hist[j]) if (hist[j] == lvl) all_diff = 0;
        if (all_diff) begin
          lvl  = !lvl;
          rose = lvl;
          hist.delete();
        end
      end
      case (ph)
        M_IDLE: if (prs) ph = M_REQ;
        M_REQ: if (ar) begin ph = M_WALK; left = WC; end
        M_WALK, M_FLASH: begin
          if (!ar) begin
            ph = M_COOL; left = CC;
          end else begin
            left--;
            if (left == 0) begin
              if (ph == M_WALK) begin ph = M_FLASH; left = FC; end
              else begin ph = M_COOL; left = CC; end
            end
          end
        end
        M_COOL: begin
          if (prs) pend = 1;
          left--;
          if (left == 0) begin
            ph   = pend ? M_REQ : M_IDLE;
            pend = 0;
          end
        end
        default: ph = M_IDLE;
      endcase
    end
  end

  function automatic bit m_dont_walk();
    if (ph == M_WALK) return 1'b0;
    if (ph == M_FLASH) return ((FC - left) % 2) == 0;
    return 1'b1;
  endfunction

  // Every falling edge: DUT outputs against the model and the lamp exclusivity rule.
  always @(negedge clk) begin
    check("model_button", button, (ph == M_REQ));
    check("model_walk", walk, (ph == M_WALK));
    check("model_dont_walk", dont_walk, m_dont_walk());
    check("model_req_lamp", req_lamp, (ph == M_REQ) || (ph == M_COOL && pend));
    check("walk_dont_walk_exclusive", walk & dont_walk, 1'b0);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lamps(input bit red);
    {A1, A2, B, C} = red ? 4'b0000 : 4'b1001;
  endtask

  task automatic wait_button(input string name, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (button === 1'b1) begin
        n = i;
        break;
      end
    end
    check(name, (n >= 1 && n <= DB + 3), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_button"}, button, 0);
    check({tag, "_walk"}, walk, 0);
    check({tag, "_dont_walk"}, dont_walk, 1);
    check({tag, "_req_lamp"}, req_lamp, 0);
  endtask

  int n;
  int ped_left, lamp_left, r;

  initial begin
    reset_n = 1'b1;
    ped_raw = 1'b0;
    lamps(0);
    #1 reset_n = 1'b0;
    #1 check_reset_vals("reset_initial");
    cyc(2);
    reset_n = 1'b1;

    // Glitch shorter than the debounce window.
    cyc(2);
    ped_raw = 1'b1;
    cyc(3);
    ped_raw = 1'b0;
    cyc(12);
    check("glitch_button", button, 0);
    check("glitch_req_lamp", req_lamp, 0);

    // Full crossing.
    ped_raw = 1'b1;
    wait_button("press_latency", n);
    check("req_lamp_with_button", req_lamp, 1);
    if (n < 10) cyc(10 - n);
    ped_raw = 1'b0;
    cyc(5);
    check("button_held", button, 1);
    lamps(1);
    for (int k = 0; k < WC; k++) begin
      cyc(1);
      check("walk_phase_walk", walk, 1);
      check("walk_phase_button", button, 0);
    end
    for (int k = 0; k < FC; k++) begin
      cyc(1);
      check("flash_walk", walk, 0);
      check("flash_pattern", dont_walk, (k % 2) == 0);
    end
    for (int k = 0; k < CC; k++) begin
      cyc(1);
      check("cool_dont_walk", dont_walk, 1);
      check("cool_button", button, 0);
      if (k == 0) lamps(0);
    end

    // Safety abort on WALK cycle 4.
    ped_raw = 1'b1;
    wait_button("abort_press_latency", n);
    if (n < 8) cyc(8 - n);
    ped_raw = 1'b0;
    lamps(1);
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      check("abort_walk_before", walk, 1);
    end
    lamps(0);
    cyc(1);
    check("abort_walk", walk, 0);
    check("abort_dont_walk", dont_walk, 1);

    // Press during cooldown, released only when cooldown expires.
    for (int k = 2; k <= CC + 1; k++) begin
      cyc(1);
      if (k <= 4) check("cool_req_lamp_before", req_lamp, 0);
      if (k == 15) check("cool_req_lamp_pending", req_lamp, 1);
      if (k <= CC) check("cool_pending_button", button, 0);
      else check("cool_exit_button", button, 1);
      if (k == 5) ped_raw = 1'b1;
      if (k == 13) ped_raw = 1'b0;
    end
    cyc(3);
    check("request_after_cool", button, 1);

    // Reset in the middle of WALK with the button held through it.
    lamps(1);
    cyc(4);
    check("mid_walk_walk", walk, 1);
    ped_raw = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_reset_vals("reset_mid_walk");
    lamps(0);
    cyc(2);
    reset_n = 1'b1;
    for (int k = 1; k <= DB + 3; k++) begin
      cyc(1);
      if (k <= DB + 1) check("post_reset_no_button", button, 0);
      if (k == DB + 3) check("post_reset_fresh_press", button, 1);
    end
    ped_raw = 1'b0;
    lamps(1);
    cyc(40);

    // Randomized traffic, occasional asynchronous resets.
    ped_left  = 0;
    lamp_left = 0;
    for (int i = 0; i < 4000; i++) begin
      cyc(1);
      if (ped_left == 0) begin
        ped_raw  = 1'($urandom_range(0, 1));
        ped_left = $urandom_range(1, 12);
      end else begin
        ped_left--;
      end
      if (lamp_left == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4) lamps(1);
        else if (r < 8) lamps(0);
        else {A1, A2, B, C} = 4'($urandom_range(0, 15));
        lamp_left = $urandom_range(1, 40);
      end else begin
        lamp_left--;
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 reset_n = 1'b0;
        #1 check_reset_vals("reset_random");
        @(negedge clk);
        reset_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pedestrian_request_unit.md
# pedestrian_request_unit

Pedestrian-side companion to the traffic lights controller. Debounces the raw crossing push-button and raises the controller's `button` request. It watches the controller's lamp outputs for the all-lamps-off (MODE0) crossing phase and drives the WALK / DON'T WALK signal heads for that phase. It then enforces a cooldown before it accepts another request.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required to change the debounced button level.
- `WALK_CYCLES`, 10: cycles `walk` is held high.
- `FLASH_CYCLES`, 5: cycles of flashing `dont_walk` after WALK.
- `COOLDOWN_CYCLES`, 20: cycles after a crossing before a new request may be issued.
- `CNT_W`, 5: width of the shared phase counter and the debounce counter. It must hold the largest parameter minus 1.
- Constraint: `WALK_CYCLES + FLASH_CYCLES <= 15`, so the crossing fits in the controller's 16-cycle all-off phase.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `ped_raw`, in, 1: raw, asynchronous push-button. Active high, may bounce.
- `A1`, `A2`, `B`, `C`, in, 1 each: lamp outputs from the controller.
- `button`, out, 1: request to the controller.
- `walk`, out, 1: WALK lamp.
- `dont_walk`, out, 1: DON'T WALK lamp.
- `req_lamp`, out, 1: "request registered" indicator.

## Operation

- **Synchronizer:** `ped_raw` passes through a 2-FF synchronizer.
- **Debounce:** the debounce counter counts edges on which the synchronized value differs from the debounced level, and resets on any edge where they agree. When the count reaches `DEBOUNCE_CYCLES`, the debounced level flips.
- **Press event:** a press is the rising edge of the debounced level.
- **`all_red`:** defined as `~A1 & ~A2 & ~B & ~C`, sampled on `clk`.
- **Moore FSM:** states IDLE, REQUEST, WALK, FLASH, COOLDOWN. All outputs are registered and decoded from the next state, so they change on the same edge as the state.

State behaviour:
- **IDLE:** `button`=0, `walk`=0, `dont_walk`=1, `req_lamp`=0.
  - On a press, go to REQUEST.
- **REQUEST:** `button`=1, `req_lamp`=1, `dont_walk`=1.
  - Additional presses are ignored.
  - On the first edge with `all_red`=1, go to WALK and load the counter with `WALK_CYCLES-1`.
- **WALK:** `button`=0, `req_lamp`=0, `walk`=1, `dont_walk`=0.
  - The counter decrements each edge.
  - At 0, go to FLASH and load the counter with `FLASH_CYCLES-1`.
- **FLASH:** `walk`=0.
  - `dont_walk`=1 on the first FLASH cycle, then toggles every cycle.
  - At 0, go to COOLDOWN and load the counter with `COOLDOWN_CYCLES-1`.
- **Safety abort:** in WALK or FLASH, any edge with `all_red`=0 sends the FSM to COOLDOWN immediately. On that same edge `walk`=0 and `dont_walk`=1, and the counter loads `COOLDOWN_CYCLES-1`. The abort takes priority over counter expiry.
- **COOLDOWN:** `dont_walk`=1, `button`=0.
  - A press during COOLDOWN sets `pending` and `req_lamp`=1.
  - At counter 0, go to REQUEST if `pending`, otherwise IDLE. `pending` is cleared on leaving COOLDOWN.
- **Counter arithmetic:** unsigned, never wraps. Decrement only when the counter is nonzero.

Reset:
- While `reset_n`=0, asynchronously and without a clock edge:
  - state = IDLE;
  - `button`=0, `walk`=0, `dont_walk`=1, `req_lamp`=0;
  - synchronizer, debounced level, debounce counter, phase counter and `pending` all 0.
- A reset mid-operation abandons the crossing.
- A button held through reset deassertion produces a fresh press after the debounce latency.

## Timing

- **Press latency:** `button` rises at most `DEBOUNCE_CYCLES+3` edges after `ped_raw` rises: 2 synchronizer edges, `DEBOUNCE_CYCLES` debounce edges, 1 FSM edge. With defaults this is ≤ 7.
- **Glitch rejection:** pulses shorter than `DEBOUNCE_CYCLES` cycles, or bounce that never holds for `DEBOUNCE_CYCLES` consecutive samples, produce no press.
- **`button` hold:** `button` stays high continuously from REQUEST entry until the edge after `all_red` is first seen. It never pulses.
- **WALK and FLASH widths:**
  - `walk` is high for exactly `WALK_CYCLES` cycles, starting the edge after `all_red` is sampled.
  - FLASH lasts exactly `FLASH_CYCLES` cycles.
- **Cooldown:** COOLDOWN lasts exactly `COOLDOWN_CYCLES` cycles.
- **Output invariants:** `walk` and `dont_walk` are never both 1. `walk` is only ever 1 in WALK.

## Test plan

1. **Async reset:** drive `reset_n`=0 between clock edges → immediately `button`=0, `walk`=0, `dont_walk`=1, `req_lamp`=0.
2. **Glitch rejection:** `ped_raw` high for 3 cycles with lamps A1=1, C=1 → `button` stays 0 and the state stays IDLE.
3. **Full crossing:** hold `ped_raw` for 10 cycles, lamps A1=1, C=1 → `button`=1 and `req_lamp`=1 within 7 edges, held until the lamps go all-0. Then:
   - `walk`=1 for 10 cycles;
   - `dont_walk` = 1,0,1,0,1 over 5 cycles;
   - `dont_walk`=1 for 20 cycles, then IDLE.
4. **Safety abort:** lamps leave all-0 on WALK cycle 4 → on that edge `walk`=0 and `dont_walk`=1, COOLDOWN is entered, and the next IDLE arrives exactly 20 cycles later.
5. **Press during cooldown:** press at COOLDOWN cycle 5 → `req_lamp`=1 after debounce, `button`=0 until cooldown ends, and `button`=1 on the edge COOLDOWN exits.
6. **Reset mid-WALK, then re-request:** assert `reset_n`=0 mid-WALK → reset values without a clock edge. After release, no `button` until a new debounced press is seen.
